xbar_port_ctrl: RTL

Crossbar target-port controller that sits directly downstream of the round-robin `arbiter`. It consumes the registered one-hot `grant` vector, captures the granted master's transaction, and drives it onto a single slave port. It runs the slave request/acknowledge handshake, returns read data and acknowledge to the granted master, and produces the one-cycle `arb_ack` pulse whose falling edge advances the arbiter's rotate pointer. A timeout counter guarantees that a silent slave cannot lock the port.

---
 rtl/xbar_port_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/xbar_port_ctrl.sv
// Crossbar target-port controller: takes the arbiter's one-hot grant, runs one
// slave transaction on behalf of the granted master, returns ack/data/error,
// and pulses arb_ack once per transaction so the arbiter can rotate.
module xbar_port_ctrl #(
    parameter int unsigned N   = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned TMO = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    grant,
    input  logic [N-1:0]    m_req,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N-1:0]    m_we,
    input  logic [N*DW-1:0] m_wdata,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic [DW-1:0]   m_rdata,
    output logic            s_req,
    output logic [AW-1:0]   s_addr,
    output logic            s_we,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_rdata,
    output logic            arb_ack,
    output logic            grant_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_HOLD0 = 3'd3,
        ST_HOLD1 = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  w_idx_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;

    logic           w_onehot;
    logic           w_multi;
    logic [IW-1:0]  w_gidx;
    logic           w_sel_req;
    logic [AW-1:0]  w_sel_addr;
    logic           w_sel_we;
    logic [DW-1:0]  w_sel_wdata;
    logic [N-1:0]   w_idx_1h;

    logic [N-1:0]   w_m_ack_nxt;
    logic [N-1:0]   w_m_err_nxt;
    logic [DW-1:0]  w_m_rdata_nxt;
    logic           w_s_req_nxt;
    logic [AW-1:0]  w_s_addr_nxt;
    logic           w_s_we_nxt;
    logic [DW-1:0]  w_s_wdata_nxt;
    logic           w_arb_ack_nxt;
    logic           w_grant_err_nxt;

    // Grant qualification, one-hot-to-binary encode and granted-master mux
    always_comb begin
        w_onehot    = (grant != '0) && ((grant & (grant - N'(1))) == '0);
        w_multi     = (grant != '0) && !w_onehot;
        w_gidx      = '0;
        w_sel_req   = 1'b0;
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_gidx = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gidx == IW'(i)) begin
                w_sel_req   = m_req[i];
                w_sel_addr  = m_addr[i*AW +: AW];
                w_sel_we    = m_we[i];
                w_sel_wdata = m_wdata[i*DW +: DW];
            end
        end
        w_idx_1h = N'(1) << r_idx;
    end

    // Next-state and next-output logic; outputs are registered below
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_m_ack_nxt     = '0;
        w_m_err_nxt     = '0;
        w_m_rdata_nxt   = m_rdata;
        w_s_req_nxt     = 1'b0;
        w_s_addr_nxt    = s_addr;
        w_s_we_nxt      = s_we;
        w_s_wdata_nxt   = s_wdata;
        w_arb_ack_nxt   = 1'b0;
        w_grant_err_nxt = grant_err;

        case (r_state)
            ST_IDLE: begin
                if (w_multi) begin
                    w_grant_err_nxt = 1'b1;
                end else if (w_onehot && w_sel_req) begin
                    w_idx_nxt     = w_gidx;
                    w_s_addr_nxt  = w_sel_addr;
                    w_s_we_nxt    = w_sel_we;
                    w_s_wdata_nxt = w_sel_wdata;
                    w_cnt_nxt     = '0;
                    w_s_req_nxt   = 1'b1;
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                // A slave ack wins over a timeout landing on the same cycle
                if (s_ack) begin
                    w_m_rdata_nxt = s_rdata;
                    w_m_ack_nxt   = w_idx_1h;
                    w_arb_ack_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_RESP;
                end else if ((r_cnt + CW'(1)) >= CW'(TMO)) begin
                    w_m_rdata_nxt = '0;
                    w_m_ack_nxt   = w_idx_1h;
                    w_m_err_nxt   = w_idx_1h;
                    w_arb_ack_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_s_req_nxt = 1'b1;
                end
            end
            ST_RESP:  w_state_nxt = ST_HOLD0;
            ST_HOLD0: w_state_nxt = ST_HOLD1;
            ST_HOLD1: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            m_ack     <= '0;
            m_err     <= '0;
            m_rdata   <= '0;
            s_req     <= 1'b0;
            s_addr    <= '0;
            s_we      <= 1'b0;
            s_wdata   <= '0;
            arb_ack   <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            m_ack     <= w_m_ack_nxt;
            m_err     <= w_m_err_nxt;
            m_rdata   <= w_m_rdata_nxt;
            s_req     <= w_s_req_nxt;
            s_addr    <= w_s_addr_nxt;
            s_we      <= w_s_we_nxt;
            s_wdata   <= w_s_wdata_nxt;
            arb_ack   <= w_arb_ack_nxt;
            grant_err <= w_grant_err_nxt;
        end
    end

endmodule
